// File: rtl/poseidon_pkg.sv
// Shared definitions for the Poseidon hash core.
//
// Purpose: field element width, sponge arity, the field element type and
// the input framer state encoding, shared by the framer and the core.
// Ports: none (package).
package poseidon_pkg;

  localparam int FIELD_W        = 255;
  localparam int POSEIDON_ARITY = 3;

  typedef logic [FIELD_W-1:0] field_t;

  typedef enum logic [0:0] {
    PASS = 1'b0,
    PAD  = 1'b1
  } framer_state_t;

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register slot carrying data plus a last flag.
//
// Purpose: registers one stream beat; accepts a new beat whenever the slot
// is empty or is being drained in the same cycle, so full throughput is
// kept with the consumer always ready.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake
//   in_data/in_last      upstream beat
//   out_valid/out_ready  downstream handshake
//   out_data/out_last    registered beat (held stable while stalled)
module stream_reg_slice #(
  parameter int WIDTH = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // A load into a full slot is only allowed when the current beat leaves
  // in the same cycle, so the slot stays full across a drain+load.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/poseidon_input_framer.sv
// Poseidon input framer.
//
// Purpose: groups the host element stream into frames of ARITY elements,
// flags the final element of each frame with m_last, and completes a
// message that ends mid-frame with PAD_VALUE elements. Counts completed
// frames and emitted padding elements.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_end host element stream (s_end = message end)
//   m_valid/m_ready/m_data/m_last element stream into the hash core
//   frame_count                  frames handed to the core (wraps)
//   pad_count                    padding elements emitted (wraps)
//   busy                         partial frame, padding or output pending
module poseidon_input_framer
  import poseidon_pkg::*;
#(
  parameter int               WIDTH     = FIELD_W,
  parameter int               ARITY     = POSEIDON_ARITY,
  parameter logic [WIDTH-1:0] PAD_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_end,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] pad_count,
  output logic             busy
);

  localparam int IDX_W = $clog2(ARITY);
  localparam int PAD_W = $clog2(ARITY);

  localparam logic [0:0]       ST_PASS  = PASS;
  localparam logic [0:0]       ST_PAD   = PAD;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARITY - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PAD_W-1:0] pad_left_q, pad_left_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [CNT_W-1:0] pad_count_q, pad_count_d;

  logic             slot_ready;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_last;
  logic             host_load;
  logic             pad_load;

  // In PAD the framer itself is the slot's producer and the host is held
  // off; the beat that lands on the final index always closes the frame.
  always_comb begin
    s_ready    = (state_q == ST_PASS) && slot_ready;
    host_load  = s_valid && s_ready;
    pad_load   = (state_q == ST_PAD) && slot_ready;
    load_valid = (state_q == ST_PASS) ? s_valid : 1'b1;
    load_data  = (state_q == ST_PAD) ? PAD_VALUE : s_data;
    load_last  = (idx_q == LAST_IDX);
  end

  stream_reg_slice #(
    .WIDTH(WIDTH)
  ) u_slot (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (load_valid),
    .in_ready (slot_ready),
    .in_data  (load_data),
    .in_last  (load_last),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_data),
    .out_last (m_last)
  );

  // Frame position, padding bookkeeping and status counters. A message
  // ending on the final index needs no padding; otherwise the remaining
  // beats of the frame are filled one per free slot cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pad_left_d    = pad_left_q;
    frame_count_d = frame_count_q;
    pad_count_d   = pad_count_q;

    if (host_load || pad_load) begin
      idx_d = load_last ? '0 : idx_q + IDX_W'(1);
    end

    if (host_load && s_end && !load_last) begin
      pad_left_d = LAST_IDX - idx_q;
      state_d    = ST_PAD;
    end

    if (pad_load) begin
      pad_left_d  = pad_left_q - PAD_W'(1);
      pad_count_d = pad_count_q + CNT_W'(1);
      if (pad_left_q == PAD_W'(1)) begin
        state_d = ST_PASS;
      end
    end

    if (m_valid && m_ready && m_last) begin
      frame_count_d = frame_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_PASS;
      idx_q         <= '0;
      pad_left_q    <= '0;
      frame_count_q <= '0;
      pad_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pad_left_q    <= pad_left_d;
      frame_count_q <= frame_count_d;
      pad_count_q   <= pad_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign pad_count   = pad_count_q;
  assign busy        = (idx_q != '0) || (state_q == ST_PAD) || m_valid;

endmodule

// File: tb/tb_poseidon_input_framer.sv
// Testbench for poseidon_input_framer.
//
// Purpose: drives directed host streams, predicts the framed output
// (including padding) into a scoreboard queue, and compares every core
// beat and the status counters against those predictions.
// Ports: none (top-level bench).
module tb_poseidon_input_framer;

  localparam int WIDTH = 255;
  localparam int ARITY = 3;
  localparam int CNT_W = 8;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic             clk;
  logic             resetn;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_end;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] pad_count;
  logic             busy;

  beat_t            sb[$];
  int               pos;
  bit               hs_seen;
  bit               stalled;
  logic [WIDTH-1:0] held_data;
  logic             held_last;
  int               n_asserts;
  int               n_fail;

  poseidon_input_framer #(
    .WIDTH    (WIDTH),
    .ARITY    (ARITY),
    .PAD_VALUE('0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_end      (s_end),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_count(frame_count),
    .pad_count  (pad_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then return 1 time
  // unit after the rising edge so the caller can drive the next inputs.
  task automatic tick();
    beat_t b;
    hs_seen = 1'b0;
    @(negedge clk);
    if (!resetn) begin
      sb.delete();
      pos     = 0;
      stalled = 1'b0;
    end else begin
      if (s_valid && s_ready) begin
        hs_seen = 1'b1;
        b.data  = s_data;
        b.last  = (pos == ARITY - 1);
        sb.push_back(b);
        if (s_end && pos != ARITY - 1) begin
          for (int p = pos + 1; p < ARITY; p++) begin
            b.data = '0;
            b.last = (p == ARITY - 1);
            sb.push_back(b);
          end
          pos = 0;
        end else begin
          pos = (pos + 1) % ARITY;
        end
      end
      if (stalled) begin
        checkOutput("stall_hold_data", m_data, held_data);
        checkOutput("stall_hold_last", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        checkOutput("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          b = sb.pop_front();
          checkOutput("beat_data", m_data, b.data);
          checkOutput("beat_last", m_last, b.last);
        end
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one host element and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic e, input bit rnd_ready);
    s_valid = 1'b1;
    s_data  = d;
    s_end   = e;
    for (int i = 0; i < 100; i++) begin
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (hs_seen) break;
    end
    checkOutput("host_accept", hs_seen, 1);
    s_valid = 1'b0;
    s_end   = 1'b0;
  endtask

  task automatic drain(input bit rnd_ready);
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    checkOutput("drain_done", sb.size() == 0, 1);
    m_ready = 1'b1;
    tick();
    checkOutput("idle_m_valid", m_valid, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  task automatic doReset();
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_end   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    pos       = 0;
    stalled   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    checkOutput("rst_pad_count", pad_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_s_ready", s_ready, 1);

    // 300 contiguous elements at full rate
    m_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      checkOutput("full_rate_s_ready", s_ready, 1);
      if (i > 1) checkOutput("full_rate_m_valid", m_valid, 1);
      applyStimulus(WIDTH'(i), 1'b0, 1'b0);
    end
    drain(1'b0);
    checkOutput("stream_frame_count", frame_count, CNT_W'(100));
    checkOutput("stream_pad_count", pad_count, 0);

    // 4-element message -> two pad elements
    doReset();
    applyStimulus(WIDTH'('hA), 1'b0, 1'b0);
    applyStimulus(WIDTH'('hB), 1'b0, 1'b0);
    applyStimulus(WIDTH'('hC), 1'b0, 1'b0);
    applyStimulus(WIDTH'('hD), 1'b1, 1'b0);
    checkOutput("pad_s_ready_c1", s_ready, 0);
    tick();
    checkOutput("pad_s_ready_c2", s_ready, 0);
    tick();
    checkOutput("pad_s_ready_c3", s_ready, 1);
    drain(1'b0);
    checkOutput("msg4_pad_count", pad_count, 2);
    checkOutput("msg4_frame_count", frame_count, 2);

    // Message ending on the last element of a frame
    doReset();
    applyStimulus(WIDTH'(21), 1'b0, 1'b0);
    applyStimulus(WIDTH'(22), 1'b0, 1'b0);
    applyStimulus(WIDTH'(23), 1'b1, 1'b0);
    checkOutput("nopad_s_ready", s_ready, 1);
    drain(1'b0);
    checkOutput("nopad_pad_count", pad_count, 0);
    checkOutput("nopad_frame_count", frame_count, 1);

    // Random backpressure over 30 elements
    doReset();
    for (int i = 0; i < 30; i++) begin
      applyStimulus(WIDTH'(1000 + i * 7), 1'b0, 1'b1);
    end
    drain(1'b1);
    checkOutput("bp_frame_count", frame_count, 10);

    // Reset in the middle of a frame
    doReset();
    applyStimulus(WIDTH'(51), 1'b0, 1'b0);
    applyStimulus(WIDTH'(52), 1'b0, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    applyStimulus(WIDTH'(61), 1'b0, 1'b0);
    applyStimulus(WIDTH'(62), 1'b0, 1'b0);
    applyStimulus(WIDTH'(63), 1'b0, 1'b0);
    drain(1'b0);
    checkOutput("midrst_frame_count", frame_count, 1);

    // Frame counter wrap: 2^CNT_W + 1 frames
    doReset();
    for (int i = 0; i < ((1 << CNT_W) + 1) * ARITY; i++) begin
      applyStimulus(WIDTH'(i + 5), 1'b0, 1'b0);
    end
    drain(1'b0);
    checkOutput("wrap_frame_count", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
